// File: rtl/edac_req_ctrl.sv
// Request sequencer in front of the EDAC: one host read/write at a time, fixed issue/update sequence,
// response capture and a saturating uncorrectable-read counter. Optional retry path: EDAC_RETRY_EN.
module edac_req_ctrl #(
  parameter logic [31:0] ERROR_CODE = 32'hFFFFFFFF,
  parameter int          CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_read,
  input  logic [31:0]      req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             edac_en,
  output logic             edac_sel,
  output logic             edac_read,
  output logic [31:0]      edac_din,
  input  logic [31:0]      edac_dout,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, UPDATE, RESP} state_t;
  state_t state;

  logic dout_err, retry, inc;

  // edac_read doubles as the latched read flag; it only changes on request acceptance
  assign dout_err  = edac_read && (edac_dout == ERROR_CODE);
  assign req_ready = (state == IDLE);
  assign inc       = (state == UPDATE) && !retry && dout_err;

`ifdef EDAC_RETRY_EN
  logic retried;
  assign retry = dout_err && !retried;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                        retried <= 1'b0;
    else if (state == IDLE)              retried <= 1'b0;
    else if (state == UPDATE && retry)   retried <= 1'b1;
  end
`else
  assign retry = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      edac_en   <= 1'b0;
      edac_sel  <= 1'b1;
      edac_read <= 1'b0;
      edac_din  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          edac_read <= req_read;
          edac_din  <= req_data;
          edac_en   <= 1'b1;
          edac_sel  <= 1'b0;
          state     <= ISSUE;
        end
        ISSUE: begin
          edac_en  <= 1'b0;
          edac_sel <= 1'b1;
          state    <= UPDATE;
        end
        UPDATE: begin
          rsp_data <= edac_dout;
          if (retry) begin
            // replay with the stimulus still held on edac_read/edac_din
            edac_en  <= 1'b1;
            edac_sel <= 1'b0;
            state    <= ISSUE;
          end else begin
            rsp_err   <= dout_err;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clear wins over count, but an event landing on the clear cycle still registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                    err_count <= '0;
    else if (err_clr)                err_count <= CNT_W'(inc);
    else if (inc && !(&err_count))   err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_edac_req_ctrl.sv
// Directed bench for edac_req_ctrl with a registered EDAC stand-in; builds with or without EDAC_RETRY_EN.
module tb_edac_req_ctrl;

`ifdef EDAC_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam logic [31:0] FAIL_CW  = 32'hDEAD0000;
  localparam logic [31:0] RETRY_CW = 32'hBAD00002;
  localparam int          LAT_F    = RETRY ? 5 : 3;

  logic        CLK = 1'b0;
  logic        reset_n, req_valid, req_read, rsp_ready, err_clr;
  logic [31:0] req_data;
  logic        req_ready, rsp_valid, rsp_err, edac_en, edac_sel, edac_read;
  logic [31:0] rsp_data, edac_din;
  logic [31:0] edac_dout = '0;
  logic [1:0]  err_count;

  int vecs = 0, errs = 0, en_cnt = 0;
  bit flip = 1'b0;

  edac_req_ctrl #(.ERROR_CODE(32'hFFFFFFFF), .CNT_W(2)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .edac_en(edac_en), .edac_sel(edac_sel), .edac_read(edac_read), .edac_din(edac_din),
    .edac_dout(edac_dout), .err_clr(err_clr), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  // EDAC stand-in: registered DOUT. Encode = din ^ FFFF0000, decode = din ^ 0F0F0F0F,
  // FAIL_CW always uncorrectable, RETRY_CW fails once then decodes to 12345678.
  always @(posedge CLK) begin
    if (edac_en) begin
      if (!edac_read)                edac_dout <= edac_din ^ 32'hFFFF0000;
      else if (edac_din == FAIL_CW)  edac_dout <= 32'hFFFFFFFF;
      else if (edac_din == RETRY_CW) begin
        edac_dout <= flip ? 32'h12345678 : 32'hFFFFFFFF;
        flip      <= ~flip;
      end
      else                           edac_dout <= edac_din ^ 32'h0F0F0F0F;
    end
  end

  always @(posedge CLK) if (edac_en) en_cnt <= en_cnt + 1;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input bit rd, input logic [31:0] d, input int lat,
                     input logic [31:0] ed, input bit ee, input logic [1:0] ec);
    int n;
    chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_read = rd; req_data = d;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 12) begin tick(); n++; end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_data"}, 64'(rsp_data), 64'(ed));
    chk({tag, "_err"}, 64'(rsp_err), 64'(ee));
    chk({tag, "_cnt"}, 64'(err_count), 64'(ec));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int e0;
    bit pulse;
    reset_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_data = '0;
    rsp_ready = 1'b0; err_clr = 1'b0;
    repeat (2) tick();
    chk("rst_outs", {55'd0, req_ready, rsp_valid, rsp_err, edac_en, edac_sel, edac_read, err_count},
        {55'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
    chk("rst_data", {rsp_data, edac_din}, 64'd0);
    reset_n = 1'b1;
    tick();

    // write A5: cycle-by-cycle pin sequence
    req_valid = 1'b1; req_read = 1'b0; req_data = 32'h000000A5;
    tick();
    req_valid = 1'b0;
    chk("wr_c1", {edac_en, edac_sel, edac_read, req_ready, edac_din}, {4'b1000, 32'h000000A5});
    tick();
    chk("wr_c2", {edac_en, edac_sel, rsp_valid}, {3'b010});
    tick();
    chk("wr_c3", {rsp_valid, rsp_err, rsp_data}, {2'b10, 32'hFFFF00A5});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr_idle", {rsp_valid, req_ready, edac_sel}, 3'b011);

    run("rd_ok", 1'b1, 32'h11111111, 3, 32'h1E1E1E1E, 1'b0, 2'd0);
    // encoder output equal to ERROR_CODE must not flag a write
    run("wr_ff", 1'b0, 32'h0000FFFF, 3, 32'hFFFFFFFF, 1'b0, 2'd0);

    e0 = en_cnt;
    run("rd_retry", 1'b1, RETRY_CW, RETRY ? 5 : 3, RETRY ? 32'h12345678 : 32'hFFFFFFFF,
        !RETRY, RETRY ? 2'd0 : 2'd1);
    chk("retry_issues", 64'(en_cnt - e0), RETRY ? 64'd2 : 64'd1);

    // backpressure with a second request waiting
    req_valid = 1'b1; req_read = 1'b1; req_data = 32'h22222222;
    tick();
    req_data = 32'h33333333;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, req_ready, rsp_err, edac_en, rsp_data}, {4'b1000, 32'h2D2D2D2D});
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_noacc", {req_ready, edac_en, rsp_valid}, 3'b100);
    tick();
    req_valid = 1'b0;
    chk("bp_acc2", {edac_en, edac_din}, {1'b1, 32'h33333333});
    tick(); tick();
    chk("bp_rsp2", {rsp_valid, rsp_data}, {1'b1, 32'h3C3C3C3C});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_alone", 64'(err_count), 64'd0);

    for (int k = 1; k <= 4; k++)
      run("sat", 1'b1, FAIL_CW, LAT_F, 32'hFFFFFFFF, 1'b1, (k > 3) ? 2'd3 : 2'(k));

    // fifth error lands on the same edge as err_clr
    req_valid = 1'b1; req_read = 1'b1; req_data = FAIL_CW;
    tick();
    req_valid = 1'b0;
    repeat (LAT_F - 2) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_inc", {rsp_valid, rsp_err, err_count}, {2'b11, 2'd1});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // async reset in the middle of ISSUE
    req_valid = 1'b1; req_read = 1'b0; req_data = 32'h0000A5A5;
    tick();
    req_valid = 1'b0;
    chk("ab_issue", 64'(edac_en), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ab_async", {edac_en, edac_sel, req_ready, rsp_valid, err_count}, {4'b0110, 2'd0});
    tick();
    reset_n = 1'b1;
    pulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) pulse = 1'b1;
    end
    chk("ab_after", {pulse, req_ready, edac_en, err_count}, {3'b010, 2'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
